// File: rtl/fc_12_feeder.sv
// Producer for fc_12: serializes packed weight words onto the 1-bit load port, streams
// 12-lane vectors, forwards results. Optional stall counter: define FC_FEED_STALL_CNT_EN.
module fc_12_feeder #(
    parameter int WEIGHT_BITS = 192,
    parameter int WW          = 8,
    parameter int LANES       = 12,
    parameter int DW          = 32,
    parameter int NUM_VECS    = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [WW-1:0]         w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [LANES*DW-1:0]   d_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    output logic                  weight,
    output logic                  weight_en,
    output logic                  ivalid,
    output logic [DW-1:0]         din_0,
    output logic [DW-1:0]         din_1,
    output logic [DW-1:0]         din_2,
    output logic [DW-1:0]         din_3,
    output logic [DW-1:0]         din_4,
    output logic [DW-1:0]         din_5,
    output logic [DW-1:0]         din_6,
    output logic [DW-1:0]         din_7,
    output logic [DW-1:0]         din_8,
    output logic [DW-1:0]         din_9,
    output logic [DW-1:0]         din_10,
    output logic [DW-1:0]         din_11,
    input  logic                  ovalid,
    input  logic [DW-1:0]         dout,
    output logic                  res_valid,
    output logic [DW-1:0]         res_data
`ifdef FC_FEED_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int BCW = $clog2(WEIGHT_BITS + 1);
    localparam int VCW = $clog2(NUM_VECS + 1);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int SW  = (WW > 1) ? $clog2(WW) : 1;

    localparam logic [BCW-1:0] LAST_BIT = BCW'(WEIGHT_BITS - 1);
    localparam logic [SW-1:0]  LAST_IDX = SW'(WW - 1);
    localparam logic [VCW-1:0] VEC_MAX  = VCW'(NUM_VECS);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t         state;
    logic [BCW-1:0] bit_cnt;
    logic [VCW-1:0] vec_cnt;
    logic [TW-1:0]  timer;
    logic [WW-1:0]  sh;
    logic           f;
    logic [SW-1:0]  shift_idx;
    logic [DW-1:0]  lane [LANES];
    logic           w_hs;
    logic           d_hs;

    // Re-arm on the last bit of a word so the next word lands without a bubble.
    assign w_ready = (state == LOAD_W) &&
                     (!f || (shift_idx == LAST_IDX && bit_cnt < LAST_BIT));
    assign d_ready = (state == STREAM) && (vec_cnt < VEC_MAX);
    assign w_hs    = w_valid && w_ready;
    assign d_hs    = d_valid && d_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            vec_cnt   <= '0;
            timer     <= '0;
            sh        <= '0;
            f         <= 1'b0;
            shift_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            weight    <= 1'b0;
            weight_en <= 1'b0;
            ivalid    <= 1'b0;
            for (int unsigned k = 0; k < LANES; k++) lane[k] <= '0;
        end else begin
            done      <= 1'b0;
            weight_en <= 1'b0;
            ivalid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_W;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        vec_cnt   <= '0;
                        err       <= 1'b0;
                        f         <= 1'b0;
                        shift_idx <= '0;
                    end
                end
                LOAD_W: begin
                    if (f) begin
                        weight    <= sh[WW-1];
                        weight_en <= 1'b1;
                        sh        <= sh << 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        shift_idx <= shift_idx + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STREAM;
                            f     <= 1'b0;
                        end else if (shift_idx == LAST_IDX) begin
                            shift_idx <= '0;
                            if (w_hs) sh <= w_data;
                            else      f  <= 1'b0;
                        end
                    end else if (w_hs) begin
                        sh        <= w_data;
                        f         <= 1'b1;
                        shift_idx <= '0;
                    end
                end
                STREAM: begin
                    if (d_hs) begin
                        for (int unsigned k = 0; k < LANES; k++) lane[k] <= d_data[k*DW +: DW];
                        ivalid  <= 1'b1;
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                    // Count already full: this cycle carries the last ivalid beat.
                    if (vec_cnt == VEC_MAX) begin
                        state <= DRAIN;
                        timer <= '0;
                    end
                end
                DRAIN: begin
                    timer <= timer + 1'b1;
                    if (ovalid) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (timer == TMO_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= ovalid;
            if (ovalid) res_data <= dout;
        end
    end

`ifdef FC_FEED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (((w_ready && !w_valid) || (d_ready && !d_valid)) && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign din_0  = lane[0];
    assign din_1  = lane[1];
    assign din_2  = lane[2];
    assign din_3  = lane[3];
    assign din_4  = lane[4];
    assign din_5  = lane[5];
    assign din_6  = lane[6];
    assign din_7  = lane[7];
    assign din_8  = lane[8];
    assign din_9  = lane[9];
    assign din_10 = lane[10];
    assign din_11 = lane[11];

endmodule

// File: tb/tb_fc_12_feeder.sv
// Bench for fc_12_feeder: table of run scenarios against a queue/array reference model.
module tb_fc_12_feeder;
    localparam int WB = 192, WW = 8, LANES = 12, DW = 32, NV = 16, TMO = 1024;
    localparam int NW = WB / WW;

    typedef struct {
        int          pat;        // 0: A5/3C words and lane k = k+100*v, 1: random
        int          stall_word; // word index held back, -1 none
        int          stall_len;  // ready cycles w_valid is withheld for that word
        int          d_gap;      // max random idle cycles before each vector
        int          ov_delay;   // DRAIN cycle that sees ovalid, -1 never
        int          ov_stream;  // pulse ovalid when this many beats seen, -1 never
        logic [31:0] ov_data;
        logic        exp_err;
        int          exp_drain;  // cycles from DRAIN entry to done
    } tv_t;

    logic clk = 1'b0;
    logic rst, start, w_valid, d_valid, ovalid;
    logic [WW-1:0] w_data;
    logic [LANES*DW-1:0] d_data;
    logic [DW-1:0] dout;
    logic busy, done, err, w_ready, d_ready, weight, weight_en, ivalid, res_valid;
    logic [DW-1:0] res_data;
    logic [DW-1:0] din_0, din_1, din_2, din_3, din_4, din_5, din_6, din_7, din_8, din_9, din_10, din_11;
    logic [DW-1:0] din_a [LANES];
`ifdef FC_FEED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic prev_ov;
    logic [DW-1:0] prev_dout, last_res;
    tv_t tbl [5];

    always #5 clk = ~clk;

    assign din_a[0] = din_0;   assign din_a[1] = din_1;   assign din_a[2] = din_2;
    assign din_a[3] = din_3;   assign din_a[4] = din_4;   assign din_a[5] = din_5;
    assign din_a[6] = din_6;   assign din_a[7] = din_7;   assign din_a[8] = din_8;
    assign din_a[9] = din_9;   assign din_a[10] = din_10; assign din_a[11] = din_11;

    fc_12_feeder #(.WEIGHT_BITS(WB), .WW(WW), .LANES(LANES), .DW(DW), .NUM_VECS(NV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
        .weight(weight), .weight_en(weight_en), .ivalid(ivalid),
        .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3), .din_4(din_4), .din_5(din_5),
        .din_6(din_6), .din_7(din_7), .din_8(din_8), .din_9(din_9), .din_10(din_10), .din_11(din_11),
        .ovalid(ovalid), .dout(dout), .res_valid(res_valid), .res_data(res_data)
`ifdef FC_FEED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_w_ready"}, 64'(w_ready), 64'(0));
        check({tag, "_d_ready"}, 64'(d_ready), 64'(0));
        check({tag, "_weight"}, 64'(weight), 64'(0));
        check({tag, "_weight_en"}, 64'(weight_en), 64'(0));
        check({tag, "_ivalid"}, 64'(ivalid), 64'(0));
        check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        for (int k = 0; k < LANES; k++) check({tag, "_din"}, 64'(din_a[k]), 64'(0));
    endtask

    // One run from start to done (or to a planted reset when rst_vec > 0).
    task automatic run_case(input tv_t tv, input int rst_vec);
        logic [WW-1:0] words [NW];
        logic [LANES*DW-1:0] vecs [NV];
        logic [WW-1:0] wd;
        int widx = 0, gapc = 0, vidx = 0, vgap = 0, nb = 0, wgap = 0, nv = 0;
        int d0 = 1 << 30, cyc = 0, ndone = 0, rdy_cnt = 0, hs_cnt = 0, stall_m = 0;
        int rst_phase = 0, post = 0;
        bit finished = 0, ovs_done = 0;

        for (int w = 0; w < NW; w++)
            words[w] = (tv.pat == 0) ? ((w % 2 == 0) ? 8'hA5 : 8'h3C) : WW'($urandom);
        for (int v = 0; v < NV; v++)
            for (int k = 0; k < LANES; k++)
                vecs[v][k*DW +: DW] = (tv.pat == 0) ? DW'(k + 100 * v) : DW'($urandom);

        while (!finished && cyc < 4000) begin
            @(negedge clk);
            if (rst_phase == 1) begin
                check_all_zero("after_rst");
                rst = 1'b0;
                rst_phase = 2;
            end else if (rst_phase == 2) begin
                check("no_done_after_rst", 64'(done), 64'(0));
                post++;
                if (post == 20) finished = 1;
            end else begin
                if (cyc == 1) begin
                    check("busy_after_start", 64'(busy), 64'(1));
                    check("err_cleared_by_start", 64'(err), 64'(0));
                end
                if (weight_en) begin
                    if (nb < WB) begin
                        wd = words[nb / WW];
                        check("weight_bit", 64'(weight), 64'(wd[WW - 1 - nb % WW]));
                    end
                    if (wgap > 0) begin
                        check("weight_gap", 64'(wgap),
                              64'((tv.stall_len > 0 && nb == tv.stall_word * WW) ? tv.stall_len : 0));
                        wgap = 0;
                    end
                    nb++;
                end else if (nb > 0 && nb < WB) begin
                    wgap++;
                end
                if (ivalid) begin
                    if (nv < NV)
                        for (int k = 0; k < LANES; k++)
                            check("din_lane", 64'(din_a[k]), 64'(vecs[nv][k*DW +: DW]));
                    nv++;
                    if (nv == NV) d0 = cyc + 1;
                end
                if (vidx == NV && ndone == 0) check("d_ready_after_last", 64'(d_ready), 64'(0));
                if (done) begin
                    ndone++;
                    if (ndone == 1) begin
                        check("done_cycle", 64'(cyc), 64'(d0 + tv.exp_drain));
                        check("err_at_done", 64'(err), 64'(tv.exp_err));
                        check("busy_at_done", 64'(busy), 64'(1));
`ifdef FC_FEED_STALL_CNT_EN
                        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
                    end
                end else if (ndone > 0) begin
                    check("busy_after_done", 64'(busy), 64'(0));
                    check("err_sticky", 64'(err), 64'(tv.exp_err));
                    finished = 1;
                end
            end

            check("res_valid", 64'(res_valid), 64'(prev_ov));
            if (prev_ov) begin
                check("res_data", 64'(res_data), 64'(prev_dout));
                last_res = prev_dout;
            end else begin
                check("res_hold", 64'(res_data), 64'(last_res));
            end

            start = (rst_phase == 0) && (cyc == 0 || cyc == 60);
            if (widx < NW) begin
                if (widx == tv.stall_word && gapc < tv.stall_len) begin
                    w_valid = 1'b0;
                    if (w_ready) gapc++;
                end else begin
                    w_valid = 1'b1;
                    w_data = words[widx];
                end
            end else begin
                w_valid = 1'b0;
            end
            if (w_ready) rdy_cnt++;
            if (w_ready && !w_valid) stall_m++;
            if (w_valid && w_ready) begin
                widx++;
                hs_cnt++;
            end

            if (vidx < NV) begin
                if (vgap > 0) begin
                    d_valid = 1'b0;
                    vgap--;
                end else begin
                    d_valid = 1'b1;
                    d_data = vecs[vidx];
                end
            end else begin
                d_valid = 1'b1;
                d_data = {LANES{32'hDEAD_BEEF}};
            end
            if (d_ready && !d_valid) stall_m++;
            if (d_valid && d_ready) begin
                vidx++;
                vgap = (tv.d_gap > 0) ? int'($urandom_range(0, tv.d_gap)) : 0;
            end

            ovalid = 1'b0;
            dout = $urandom;
            if (tv.ov_stream >= 0 && !ovs_done && nv == tv.ov_stream) begin
                ovalid = 1'b1;
                ovs_done = 1;
            end
            if (tv.ov_delay >= 0 && cyc == d0 + tv.ov_delay) begin
                ovalid = 1'b1;
                dout = tv.ov_data;
            end
            if (rst_vec > 0 && rst_phase == 0 && nv == rst_vec) begin
                rst = 1'b1;
                rst_phase = 1;
                ovalid = 1'b0;
                last_res = '0;
            end
            prev_ov = ovalid;
            prev_dout = dout;
            cyc++;
        end

        w_valid = 1'b0;
        check("run_finished", 64'(finished), 64'(1));
        if (rst_vec < 0) begin
            check("weight_bits_total", 64'(nb), 64'(WB));
            check("ivalid_beats", 64'(nv), 64'(NV));
            check("done_pulses", 64'(ndone), 64'(1));
            check("w_handshakes", 64'(hs_cnt), 64'(NW));
            check("w_ready_cycles", 64'(rdy_cnt), 64'(NW + tv.stall_len));
        end
    endtask

    initial begin
        tbl[0] = '{0, -1, 0, 0, 5, -1, 32'hFFFF_FFDB, 1'b0, 6};
        tbl[1] = '{0, 6, 3, 0, 0, -1, 32'h0000_0007, 1'b0, 1};
        tbl[2] = '{1, -1, 0, 3, 20, 3, 32'h1234_5678, 1'b0, 21};
        tbl[3] = '{1, 1, 5, 2, -1, -1, 32'h0, 1'b1, TMO};
        tbl[4] = '{1, 23, 1, 1, TMO - 2, -1, 32'h8000_0001, 1'b0, TMO - 1};

        rst = 1'b1; start = 1'b0; w_valid = 1'b0; d_valid = 1'b0; ovalid = 1'b0;
        w_data = '0; d_data = '0; dout = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_err", 64'(err), 64'(0));
        check("reset_res_data", 64'(res_data), 64'(0));
`ifdef FC_FEED_STALL_CNT_EN
        check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
        rst = 1'b0;
        prev_ov = 1'b0;
        prev_dout = '0;
        last_res = '0;

        for (int i = 0; i < 5; i++) begin
            run_case(tbl[i], -1);
            // Abort mid-STREAM after the 7th beat; the next run must reload all weight bits.
            if (i == 1) run_case(tbl[0], 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
